// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: CP0 register map, SR/Cause field
// positions and exception codes.
package mips_pkg;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int SR_IM_LO  = 10;
    localparam int SR_IM_HI  = 15;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD     = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PrID, interrupt and
// exception arbitration, mfc0/mtc0/eret service.
module cp0
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [31:0] din,
    input  logic        we,
    input  logic        exlclr,
    input  logic [31:0] pc8_m,
    input  logic        bd_m,
    input  logic [4:0]  exccode_m,
    input  logic [5:0]  hwint,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        intreq
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        irq;
    logic        exc;
    logic [31:0] sr;
    logic [31:0] cause;

    logic unused_din;
    assign unused_din = ^{din[31:16], din[9:2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    // hwint drives irq directly so a new line is seen with zero latency
    always_comb begin
        irq    = (|(hwint & im_q)) & ie_q & ~exl_q;
        exc    = (exccode_m != 5'd0) & ~exl_q;
        intreq = irq | exc;
    end

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = hwint;
        exc_d = exc_q;
        epc_d = epc_q;
        if (intreq) begin
            exl_d = 1'b1;
            bd_d  = bd_m;
            exc_d = irq ? EXC_INT : exccode_m;
            epc_d = pc8_m - (bd_m ? 32'd12 : 32'd8);
        end else if (we) begin
            if (a2 == CP0_SR) begin
                im_d  = din[SR_IM_HI:SR_IM_LO];
                exl_d = din[SR_EXL];
                ie_d  = din[SR_IE];
            end else if (a2 == CP0_EPC) begin
                epc_d = din;
            end
        end else if (exlclr) begin
            exl_d = 1'b0;
        end
    end

    always_comb begin
        sr = '0;
        sr[SR_IM_HI:SR_IM_LO] = im_q;
        sr[SR_EXL] = exl_q;
        sr[SR_IE]  = ie_q;
        cause = '0;
        cause[CAUSE_BD] = bd_q;
        cause[CAUSE_IP_HI:CAUSE_IP_LO] = ip_q;
        cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_q;
    end

    always_comb begin
        dout = '0;
        unique case (a1)
            CP0_SR:    dout = sr;
            CP0_CAUSE: dout = cause;
            CP0_EPC:   dout = epc_q;
            CP0_PRID:  dout = PRID;
            default:   dout = '0;
        endcase
    end

    assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: directed scenarios then random traffic
// against a word-level register model.
module tb_cp0;

    localparam logic [31:0] PRID_V = 32'h4D49_5053;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  a1 = '0, a2 = '0, exccode_m = '0;
    logic [31:0] din = '0, pc8_m = '0;
    logic        we = 1'b0, exlclr = 1'b0, bd_m = 1'b0;
    logic [5:0]  hwint = '0;
    logic [31:0] dout, epc_out;
    logic        intreq;

    cp0 dut (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .din(din),
        .we(we), .exlclr(exlclr), .pc8_m(pc8_m), .bd_m(bd_m),
        .exccode_m(exccode_m), .hwint(hwint), .dout(dout),
        .epc_out(epc_out), .intreq(intreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [31:0] rd;
        logic [31:0] epc;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int total = 0;
    int bad = 0;
    int issued = 0;
    int checked = 0;

    // whole-word model of architectural state
    logic [31:0] m_sr, m_cause, m_epc;

    // stimulus staging
    logic [4:0]  s_a1, s_a2, s_exc;
    logic [31:0] s_din, s_pc8;
    logic        s_we, s_clr, s_bd, s_rst;
    logic [5:0]  s_hw;

    task automatic clr();
        s_a1 = 5'd0; s_a2 = 5'd0; s_exc = 5'd0; s_din = '0;
        s_pc8 = 32'h0000_1008; s_we = 0; s_clr = 0; s_bd = 0;
        s_hw = '0; s_rst = 0;
    endtask

    task automatic model_reset();
        m_sr = '0; m_cause = '0; m_epc = '0;
    endtask

    task automatic go();
        exp_t e;
        logic irq, exc, take;
        @(negedge clk);
        a1 = s_a1; a2 = s_a2; din = s_din; we = s_we;
        exlclr = s_clr; pc8_m = s_pc8; bd_m = s_bd;
        exccode_m = s_exc; hwint = s_hw;
        if (s_rst) begin
            reset = 1'b1;
            #1;
            reset = 1'b0;
            model_reset();
        end
        irq = ((s_hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
        exc = (s_exc != 5'd0) && !m_sr[1];
        take = irq || exc;
        e.irq = take;
        e.epc = m_epc;
        case (s_a1)
            5'd12: e.rd = m_sr;
            5'd13: e.rd = m_cause;
            5'd14: e.rd = m_epc;
            5'd15: e.rd = PRID_V;
            default: e.rd = '0;
        endcase
        q.push_back(e);
        issued++;
        -> chk_ev;
        // state after the coming rising edge
        m_cause[15:10] = s_hw;
        if (take) begin
            m_sr = m_sr | 32'h2;
            m_cause[31] = s_bd;
            m_cause[6:2] = irq ? 5'd0 : s_exc;
            m_epc = s_pc8 - (s_bd ? 32'd12 : 32'd8);
        end else if (s_we) begin
            if (s_a2 == 5'd12) m_sr = s_din & 32'h0000_FC03;
            else if (s_a2 == 5'd14) m_epc = s_din;
        end else if (s_clr) begin
            m_sr = m_sr & ~32'h2;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(chk_ev);
            #2;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL empty_queue at %0t", $time);
            end else begin
                e = q.pop_front();
                checked++;
                total++;
                if (intreq !== e.irq) begin
                    bad++;
                    $display("FAIL intreq a1=%0d got=%b exp=%b t=%0t",
                             a1, intreq, e.irq, $time);
                end
                total++;
                if (dout !== e.rd) begin
                    bad++;
                    $display("FAIL dout a1=%0d got=%h exp=%h t=%0t",
                             a1, dout, e.rd, $time);
                end
                total++;
                if (epc_out !== e.epc) begin
                    bad++;
                    $display("FAIL epc_out got=%h exp=%h t=%0t",
                             epc_out, e.epc, $time);
                end
            end
        end
    end

    initial begin : driver
        int waitc;
        model_reset();
        clr();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 12; i <= 16; i++) begin
            clr(); s_a1 = 5'(i); go();
        end

        // interrupt on a non-delay-slot instruction
        clr(); s_we = 1; s_a2 = 5'd12; s_din = 32'h0000_0401; go();
        clr(); s_hw = 6'b000001; s_pc8 = 32'h0000_3010; s_a1 = 5'd14; go();
        clr(); s_a1 = 5'd14; go();
        clr(); s_a1 = 5'd13; go();
        clr(); s_a1 = 5'd12; go();

        // overflow in a delay slot
        clr(); s_we = 1; s_a2 = 5'd12; s_din = 32'h0; go();
        clr(); s_exc = 5'd12; s_bd = 1; s_pc8 = 32'h0000_3020; go();
        clr(); s_a1 = 5'd14; go();
        clr(); s_a1 = 5'd13; go();

        // blocked while EXL, then eret reopens
        clr(); s_we = 1; s_a2 = 5'd12; s_din = 32'h0000_0403; go();
        clr(); s_exc = 5'd10; s_hw = 6'b1; s_a1 = 5'd13; go();
        clr(); s_exc = 5'd10; s_hw = 6'b1; s_clr = 1; s_a1 = 5'd12; go();
        clr(); s_hw = 6'b1; s_pc8 = 32'h0000_5008; s_a1 = 5'd12; go();
        clr(); s_a1 = 5'd13; go();

        // exception beats a same-cycle mtc0 EPC; misaligned PC kept exact
        clr(); s_we = 1; s_a2 = 5'd12; s_din = 32'h0; go();
        clr(); s_exc = 5'd4; s_we = 1; s_a2 = 5'd14;
        s_din = 32'h1234_5678; s_pc8 = 32'h0000_4003; go();
        clr(); s_a1 = 5'd14; go();
        clr(); s_a1 = 5'd13; go();

        // async reset between edges
        clr(); s_we = 1; s_a2 = 5'd14; s_din = 32'h0000_3000; go();
        clr(); s_we = 1; s_a2 = 5'd12; s_din = 32'h0000_0002; go();
        clr(); s_a1 = 5'd14; go();
        clr(); s_rst = 1; s_a1 = 5'd12; go();
        clr(); s_a1 = 5'd13; go();
        clr(); s_a1 = 5'd14; go();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            clr();
            s_a1 = 5'($urandom_range(10, 17));
            s_we = ($urandom_range(0, 3) == 0);
            s_a2 = 5'($urandom_range(11, 16));
            s_din = $urandom;
            if ($urandom_range(0, 1) == 0) s_din[1] = 1'b0;
            s_clr = ($urandom_range(0, 4) == 0);
            s_pc8 = $urandom;
            s_bd = 1'($urandom_range(0, 1));
            s_exc = ($urandom_range(0, 5) == 0) ?
                    5'($urandom_range(1, 31)) : 5'd0;
            s_hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            s_rst = ($urandom_range(0, 60) == 0);
            go();
        end

        waitc = 0;
        while (checked < issued && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        #4;
        total++;
        if (checked != issued) begin
            bad++;
            $display("FAIL drain checked=%0d issued=%0d", checked, issued);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
